// File: rtl/crack_sched_pkg.sv
// Shared types and constants for the password-crack scheduler and its BCD incrementer.
package crack_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDispatch,
    StDrain,
    StDone
  } sched_state_e;

  localparam int unsigned BcdW     = 4;
  localparam int unsigned PwDigits = 8;
  localparam logic [31:0] BcdMax   = 32'h9999_9999;

endpackage

// File: rtl/crack_scheduler_bcd_inc.sv
// Combinational 8-digit BCD incrementer: adds one unit at digit `pos`, lower digits pass through.
module bcd_inc
  import crack_sched_pkg::*;
(
  input  logic [31:0] value,
  input  logic [2:0]  pos,
  output logic [31:0] result,
  output logic        carry
);

  logic c;

  always_comb begin
    result = value;
    c      = 1'b1;
    for (int d = 0; d < int'(PwDigits); d++) begin
      if (d >= int'(pos) && c) begin
        if (value[d*BcdW +: BcdW] >= 4'd9) begin
          result[d*BcdW +: BcdW] = '0;
        end else begin
          result[d*BcdW +: BcdW] = value[d*BcdW +: BcdW] + 4'd1;
          c = 1'b0;
        end
      end
    end
    // Carry out of the top digit means the value wrapped past all nines.
    carry = c;
  end

endmodule

// File: rtl/crack_scheduler.sv
// Dispatches ascending BCD chunks to a bank of crack engines and stops all of them on first match.
// Define CRACK_SCHED_BCD_TIME_EN to make `cycles` count in 8-digit BCD instead of binary.
module crack_scheduler
  import crack_sched_pkg::*;
#(
  parameter int unsigned NUM_ENG      = 4,
  parameter int unsigned CHUNK_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [31:0]             answer,
  output logic [31:0]             cycles,
  output logic [NUM_ENG-1:0]      eng_start,
  output logic [31:0]             eng_base,
  output logic                    eng_abort,
  input  logic [NUM_ENG-1:0]      eng_busy,
  input  logic [NUM_ENG-1:0]      eng_found,
  input  logic [32*NUM_ENG-1:0]   eng_answer
);

  localparam logic [2:0] ChunkPos = 3'(CHUNK_DIGITS);

  sched_state_e       state_q, state_d;
  logic [31:0]        next_base_q, next_base_d, base_inc;
  logic               base_carry;
  logic [NUM_ENG-1:0] pending_q, pending_d, free, pick;
  logic               exhausted_q, exhausted_d;
  logic [31:0]        cycles_q, cycles_d, cycles_inc;
  logic               done_q, done_d, found_q, found_d;
  logic               busy_q, busy_d, abort_q, abort_d;
  logic [31:0]        answer_q, answer_d, eng_base_q, eng_base_d, match_answer;
  logic [NUM_ENG-1:0] eng_start_q, eng_start_d;

  bcd_inc u_base_inc (
    .value  (next_base_q),
    .pos    (ChunkPos),
    .result (base_inc),
    .carry  (base_carry)
  );

`ifdef CRACK_SCHED_BCD_TIME_EN
  logic [31:0] cyc_bcd;
  logic        cyc_carry;

  bcd_inc u_cyc_inc (
    .value  (cycles_q),
    .pos    (3'd0),
    .result (cyc_bcd),
    .carry  (cyc_carry)
  );

  assign cycles_inc = cyc_carry ? cycles_q : cyc_bcd;
`else
  assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
`endif

  // Lowest-index free engine and lowest-index matching answer.
  always_comb begin
    free         = ~eng_busy & ~pending_q;
    pick         = '0;
    match_answer = '0;
    for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
      if (free[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
      if (eng_found[i]) match_answer = eng_answer[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    next_base_d = next_base_q;
    pending_d   = pending_q & ~eng_busy;
    exhausted_d = exhausted_q;
    cycles_d    = cycles_q;
    done_d      = done_q;
    found_d     = found_q;
    answer_d    = answer_q;
    eng_base_d  = eng_base_q;
    eng_start_d = '0;
    abort_d     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cycles_d    = '0;
          next_base_d = '0;
          pending_d   = '0;
          exhausted_d = 1'b0;
          done_d      = 1'b0;
          found_d     = 1'b0;
          answer_d    = '0;
          state_d     = StDispatch;
        end
      end
      StDispatch, StDrain: begin
        cycles_d = cycles_inc;
        if (|eng_found) begin
          // A match wins over both dispatch and exhaustion in the same cycle.
          answer_d = match_answer;
          found_d  = 1'b1;
          done_d   = 1'b1;
          abort_d  = 1'b1;
          state_d  = StDone;
        end else if (state_q == StDispatch) begin
          if (|free && !exhausted_q) begin
            eng_start_d = pick;
            eng_base_d  = next_base_q;
            pending_d   = pending_d | pick;
            next_base_d = base_inc;
            if (base_carry) begin
              exhausted_d = 1'b1;
              state_d     = StDrain;
            end
          end
        end else if (&free) begin
          done_d  = 1'b1;
          found_d = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StDispatch) || (state_d == StDrain);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      next_base_q <= '0;
      pending_q   <= '0;
      exhausted_q <= 1'b0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      answer_q    <= '0;
      eng_base_q  <= '0;
      eng_start_q <= '0;
    end else begin
      state_q     <= state_d;
      next_base_q <= next_base_d;
      pending_q   <= pending_d;
      exhausted_q <= exhausted_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      found_q     <= found_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
      answer_q    <= answer_d;
      eng_base_q  <= eng_base_d;
      eng_start_q <= eng_start_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign answer    = answer_q;
  assign cycles    = cycles_q;
  assign eng_start = eng_start_q;
  assign eng_base  = eng_base_q;
  assign eng_abort = abort_q;

endmodule
